// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO widths, depth, count and stat-counter constants,
// plus the saturating increment used by the statistics counters.
package fifo_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STAT_W = 32;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready stream bundle;
// master is the adapter, slave is the FIFO/consumer side.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  fifoRdEn;
    logic [DATA_WIDTH-1:0] fifoRdData;
    logic                  fifoEmpty;
    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] outData;
    logic [1:0]            bufCount;

    modport master (
        output fifoRdEn, outValid, outData, bufCount,
        input  fifoRdData, fifoEmpty, outReady
    );
    modport slave (
        input  fifoRdEn, outValid, outData, bufCount,
        output fifoRdData, fifoEmpty, outReady
    );
endinterface

// File: rtl/fifo_rd_stream_stream_buf2.sv
// stream_buf2: 2-entry FIFO-ordered buffer with 1-bit head/tail pointers;
// the head slot is driven straight from a register.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  head_q;
    logic                  tail_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;

    assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= data_i;
                tail_q        <= ~tail_q;
            end
            if (pop_i)
                head_q <= ~head_q;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains syn_fifo's 1-cycle read port into a valid/ready stream.
// Optional FIFO_RD_STREAM_STATS_EN adds saturating pop/stall counters.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    fifo_rd_stream_if.master  bus
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [STAT_W-1:0] statWords,
    output logic [STAT_W-1:0] statStalls
`endif
);
    generate
        if (BUF_DEPTH != 2) begin : g_depth_chk
            $error("fifo_rd_stream: BUF_DEPTH must be 2");
        end
    endgenerate

    logic       in_flight_q;
    logic       pop;
    logic [2:0] level;

    // Reserve a slot for every outstanding read so no returning word is ever dropped.
    assign pop          = bus.outValid & bus.outReady;
    assign level        = {1'b0, bus.bufCount} + {2'b0, in_flight_q} - {2'b0, pop};
    assign bus.fifoRdEn = reset & ~bus.fifoEmpty & (level < 3'd2);
    assign bus.outValid = bus.bufCount != 2'd0;

    always_ff @(posedge clk) begin
        if (!reset)
            in_flight_q <= 1'b0;
        else
            in_flight_q <= bus.fifoRdEn;
    end

    stream_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_flight_q),
        .pop_i   (pop),
        .data_i  (bus.fifoRdData),
        .data_o  (bus.outData),
        .count_o (bus.bufCount)
    );

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [STAT_W-1:0] stat_words_q;
    logic [STAT_W-1:0] stat_stalls_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (pop)
                stat_words_q <= sat_inc(stat_words_q);
            if (bus.outValid & ~bus.outReady)
                stat_stalls_q <= sat_inc(stat_stalls_q);
        end
    end

    assign statWords  = stat_words_q;
    assign statStalls = stat_stalls_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized scoreboard bench; a queue models syn_fifo and
// the expected stream order, a negedge monitor pops and compares.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic       hold_q = 1'b0;
    logic [7:0] hold_d = '0;

    fifo_rd_stream_if #(.DATA_WIDTH(8)) ifc ();

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] statWords;
    logic [31:0] statStalls;
    logic [31:0] m_words = '0;
    logic [31:0] m_stalls = '0;
`endif

    fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .statWords  (statWords),
        .statStalls (statStalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Upstream syn_fifo: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (ifc.fifoRdEn) begin
            rd_cnt++;
            if (fq.size() != 0)
                ifc.fifoRdData <= fq.pop_front();
        end
    end

    always @(negedge clk) begin
        chk("cnt_range", 32'(ifc.bufCount <= 2'd2), 1);
        chk("valid_vs_cnt", 32'(ifc.outValid), 32'(ifc.bufCount != 2'd0));
        if (ifc.fifoEmpty)
            chk("rden_on_empty", 32'(ifc.fifoRdEn), 0);
        if (!reset)
            chk("rden_in_reset", 32'(ifc.fifoRdEn), 0);
        if (hold_q) begin
            chk("hold_valid", 32'(ifc.outValid), 1);
            chk("hold_data", 32'(ifc.outData), 32'(hold_d));
        end
        hold_q = reset && ifc.outValid && !ifc.outReady;
        hold_d = ifc.outData;
        if (reset && ifc.outValid && ifc.outReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_word: got %0h expected no word at %0t", ifc.outData, $time);
            end else
                chk("data", 32'(ifc.outData), 32'(exp_q.pop_front()));
        end
`ifdef FIFO_RD_STREAM_STATS_EN
        chk("statWords", statWords, m_words);
        chk("statStalls", statStalls, m_stalls);
        if (!reset) begin
            m_words  = '0;
            m_stalls = '0;
        end else begin
            if (ifc.outValid && ifc.outReady && m_words != 32'hFFFF_FFFF)
                m_words++;
            if (ifc.outValid && !ifc.outReady && m_stalls != 32'hFFFF_FFFF)
                m_stalls++;
        end
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        ifc.fifoEmpty = (fq.size() == 0);
    endtask

    task automatic wr(input logic [7:0] d);
        fq.push_back(d);
        exp_q.push_back(d);
        ifc.fifoEmpty = 1'b0;
    endtask

    task automatic rand_wr();
        logic [FIFO_CNT_W-1:0] lvl;
        lvl = FIFO_CNT_W'(fq.size());
        if (lvl < FIFO_CNT_W'(FIFO_DEPTH) && $urandom_range(0, 3) != 0)
            wr(8'($urandom));
    endtask

    task automatic drain();
        ifc.outReady = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || ifc.outValid); i++)
            cyc();
        chk("drain_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int waits[2] = '{2, 5};
        int counts[2] = '{1, 2};
        int rd0;
        ifc.outReady  = 1'b0;
        ifc.fifoEmpty = 1'b1;
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        repeat (3) begin
            cyc();
            chk("rst_rden", 32'(ifc.fifoRdEn), 0);
            chk("rst_valid", 32'(ifc.outValid), 0);
            chk("rst_cnt", 32'(ifc.bufCount), 0);
            chk("rst_data", 32'(ifc.outData), 0);
        end
        reset = 1'b1;
        ifc.outReady = 1'b1;
        #1;
        chk("first_issue", 32'(ifc.fifoRdEn), 1);
        chk("lat_valid0", 32'(ifc.outValid), 0);
        cyc();
        #1;
        chk("lat_valid1", 32'(ifc.outValid), 0);
        cyc();
        #1;
        chk("lat_valid2", 32'(ifc.outValid), 1);
        drain();

        for (int i = 1; i <= 8; i++)
            wr(8'hA0 + 8'(i));
        cyc();
        cyc();
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_no_gap", 32'(ifc.outValid), 1);
            cyc();
            #1;
        end
        chk("stream_done", 32'(ifc.outValid), 0);

        ifc.outReady = 1'b0;
        rd0 = rd_cnt;
        for (int i = 1; i <= 5; i++)
            wr(8'hB0 + 8'(i));
        repeat (6) cyc();
        #1;
        chk("bp_reads", 32'(rd_cnt - rd0), 2);
        chk("bp_cnt", 32'(ifc.bufCount), 2);
        chk("bp_head", 32'(ifc.outData), 32'hB1);
        chk("bp_no_issue", 32'(ifc.fifoRdEn), 0);
        ifc.outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_burst", 32'(ifc.outValid), 1);
            cyc();
            #1;
        end
        chk("bp_done", 32'(ifc.outValid), 0);

        for (int i = 0; i < 40; i++) begin
            ifc.outReady = (i % 2) == 0;
            rand_wr();
            cyc();
        end
        for (int i = 0; i < 400; i++) begin
            ifc.outReady = $urandom_range(0, 2) != 0;
            rand_wr();
            cyc();
        end
        drain();

        for (int k = 0; k < 2; k++) begin
            ifc.outReady = 1'b0;
            wr(8'hC1);
            wr(8'hC2);
            wr(8'hC3);
            repeat (waits[k]) cyc();
            #1;
            chk("pre_rst_cnt", 32'(ifc.bufCount), 32'(counts[k]));
            reset = 1'b0;
            fq.delete();
            exp_q.delete();
            ifc.fifoEmpty = 1'b1;
            cyc();
            chk("mid_rst_cnt", 32'(ifc.bufCount), 0);
            chk("mid_rst_valid", 32'(ifc.outValid), 0);
            reset = 1'b1;
            ifc.outReady = 1'b1;
            for (int i = 1; i <= 4; i++)
                wr(8'hD0 + 8'(i));
            for (int i = 0; i < 30; i++) begin
                ifc.outReady = $urandom_range(0, 1) != 0;
                rand_wr();
                cyc();
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
